dram_data_responder: RTL

- Device-side (DRAM model) end of the DQ/DQS data interface. It captures controller write bursts and drives read bursts back with DQS preamble and postamble.
- Sits behind the DRAM command decoder inside the memory model. It faces the controller's data-transfer block on the data pins and a burst-wide storage port on the array side.
- Single clock domain at beat rate: one CLK cycle equals one DQ beat.

---
 rtl/dram_data_responder_pkg.sv | 28 ++
 rtl/dram_data_responder_if.sv | 44 ++++
 rtl/dram_data_responder_burst_buffer.sv | 61 ++++++
 rtl/dram_data_responder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/dram_data_responder_pkg.sv
`default_nettype none
// ==========================================================================
// dram_data_responder_pkg : shared types and default timing for the DRAM data responder
// Rev 1.0
// ==========================================================================
package dram_data_responder_pkg;

  localparam int BURST_LEN   = 8;
  localparam int DATA_BEAT_W = 32;
  localparam int DEF_WL      = 4;
  localparam int DEF_RL      = 6;
  localparam int DEF_RD_PRE  = 2;

  typedef logic [$clog2(BURST_LEN)-1:0] col_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_WAIT = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_WR_DONE = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_RD_PRE  = 3'd5,
    ST_RD_DATA = 3'd6,
    ST_RD_POST = 3'd7
  } burst_state_t;

endpackage
`default_nettype wire

// File: rtl/dram_data_responder_if.sv
`default_nettype none
// ==========================================================================
// dram_data_responder_if : command, DQ/DQS pin and array-side burst bundle
// Rev 1.0
// ==========================================================================
interface dram_data_responder_if
  import dram_data_responder_pkg::*;
#(
  parameter int DATA_W = DATA_BEAT_W,
  parameter int BURST  = BURST_LEN
);
  localparam int CW = $clog2(BURST);

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_wr;
  logic [CW-1:0]           cmd_col;
  logic [DATA_W-1:0]       dq_in;
  logic                    dqs_t_in;
  logic                    dm_n_in;
  logic [DATA_W-1:0]       dq_out;
  logic                    dq_oe;
  logic                    dqs_t_out;
  logic                    dqs_oe;
  logic                    wr_burst_valid;
  logic [BURST*DATA_W-1:0] wr_burst_data;
  logic [BURST-1:0]        wr_burst_mask;
  logic [BURST*DATA_W-1:0] rd_burst_data;
  logic                    dqs_err;

  modport master (
    output cmd_valid, cmd_wr, cmd_col, dq_in, dqs_t_in, dm_n_in, rd_burst_data,
    input  cmd_ready, dq_out, dq_oe, dqs_t_out, dqs_oe,
           wr_burst_valid, wr_burst_data, wr_burst_mask, dqs_err
  );

  modport slave (
    input  cmd_valid, cmd_wr, cmd_col, dq_in, dqs_t_in, dm_n_in, rd_burst_data,
    output cmd_ready, dq_out, dq_oe, dqs_t_out, dqs_oe,
           wr_burst_valid, wr_burst_data, wr_burst_mask, dqs_err
  );

endinterface
`default_nettype wire

// File: rtl/dram_data_responder_burst_buffer.sv
`default_nettype none
// ==========================================================================
// dram_burst_buffer : burst-wide word store with column-indexed write/read and mask
// Rev 1.0
// ==========================================================================
module dram_burst_buffer #(
  parameter  int DATA_W = 32,
  parameter  int BURST  = 8,
  localparam int CW     = $clog2(BURST)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    load_i,
  input  logic [BURST*DATA_W-1:0] load_data_i,
  input  logic                    mask_clr_i,
  input  logic                    wr_en_i,
  input  logic [CW-1:0]           wr_col_i,
  input  logic [DATA_W-1:0]       wr_data_i,
  input  logic                    wr_mask_i,
  input  logic [CW-1:0]           rd_col_i,
  output logic [DATA_W-1:0]       rd_data_o,
  output logic [BURST*DATA_W-1:0] words_o,
  output logic [BURST-1:0]        mask_o
);

  logic [DATA_W-1:0] w_word [BURST];
  logic [BURST-1:0]  mask_q;

  for (genvar g = 0; g < BURST; g++) begin : g_word
    logic [DATA_W-1:0] word_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        word_q <= '0;
      end else if (load_i) begin
        word_q <= load_data_i[g*DATA_W +: DATA_W];
      end else if (wr_en_i && (wr_col_i == CW'(g))) begin
        word_q <= wr_data_i;
      end
    end

    assign w_word[g]                    = word_q;
    assign words_o[g*DATA_W +: DATA_W]  = word_q;
  end

  // Clear wins so a fresh command never inherits enables from the last burst.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q <= '0;
    end else if (mask_clr_i) begin
      mask_q <= '0;
    end else if (wr_en_i) begin
      mask_q[wr_col_i] <= wr_mask_i;
    end
  end

  assign mask_o    = mask_q;
  assign rd_data_o = w_word[rd_col_i];

endmodule
`default_nettype wire

// File: rtl/dram_data_responder.sv
`default_nettype none
// ==========================================================================
// dram_data_responder : device-side DQ/DQS burst capture and read drive with preamble/postamble
// Rev 1.0
// ==========================================================================
module dram_data_responder
  import dram_data_responder_pkg::*;
#(
  parameter int DATA_W = DATA_BEAT_W,
  parameter int BURST  = BURST_LEN,
  parameter int WL     = DEF_WL,
  parameter int RL     = DEF_RL,
  parameter int RD_PRE = DEF_RD_PRE
) (
  input  logic                 CLK,
  input  logic                 nRST,
  dram_data_responder_if.slave bus
);

  localparam int            CW        = $clog2(BURST);
  localparam int            LAT_W     = $clog2(WL + RL + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

  burst_state_t      state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [CW-1:0]     beat_q, beat_d;
  logic [CW-1:0]     col_q;
  logic              dqs_prev_q, dqs_err_q;
  logic              wr_valid_q, wr_valid_d;
  logic              dq_oe_q, dq_oe_d;
  logic              dqs_oe_q, dqs_oe_d;
  logic              dqs_t_q, dqs_t_d;
  logic [DATA_W-1:0] dq_out_q, dq_out_d;
  logic [DATA_W-1:0] w_rd_word;
  logic [CW-1:0]     w_wr_col, w_rd_col;
  logic              w_accept, w_capture;

  assign w_accept  = (state_q == ST_IDLE) && bus.cmd_valid;
  assign w_capture = (state_q == ST_WR_DATA);
  assign w_wr_col  = col_q + beat_q;
  // Read word is looked up with the next beat so the registered DQ lines up with DQS.
  assign w_rd_col  = col_q + beat_d;

  dram_burst_buffer #(
    .DATA_W (DATA_W),
    .BURST  (BURST)
  ) u_buf (
    .clk_i       (CLK),
    .rst_ni      (nRST),
    .load_i      (w_accept && !bus.cmd_wr),
    .load_data_i (bus.rd_burst_data),
    .mask_clr_i  (w_accept),
    .wr_en_i     (w_capture),
    .wr_col_i    (w_wr_col),
    .wr_data_i   (bus.dq_in),
    .wr_mask_i   (bus.dm_n_in),
    .rd_col_i    (w_rd_col),
    .rd_data_o   (w_rd_word),
    .words_o     (bus.wr_burst_data),
    .mask_o      (bus.wr_burst_mask)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          lat_d   = '0;
          beat_d  = '0;
          state_d = bus.cmd_wr ? ((WL == 1) ? ST_WR_DATA : ST_WR_WAIT) : ST_RD_WAIT;
        end
      end
      ST_WR_WAIT: begin
        if (lat_q == LAT_W'(WL - 2)) state_d = ST_WR_DATA;
        else                         lat_d   = lat_q + LAT_W'(1);
      end
      ST_WR_DATA: begin
        beat_d = beat_q + CW'(1);
        if (beat_q == LAST_BEAT) state_d = ST_WR_DONE;
      end
      ST_WR_DONE: state_d = ST_IDLE;
      ST_RD_WAIT: begin
        if (lat_q == LAT_W'(RL - RD_PRE - 1)) begin
          lat_d   = '0;
          state_d = ST_RD_PRE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      ST_RD_PRE: begin
        if (lat_q == LAT_W'(RD_PRE - 1)) begin
          lat_d   = '0;
          beat_d  = '0;
          state_d = ST_RD_DATA;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      ST_RD_DATA: begin
        beat_d = beat_q + CW'(1);
        if (beat_q == LAST_BEAT) state_d = ST_RD_POST;
      end
      ST_RD_POST: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dq_oe_d    = (state_d == ST_RD_DATA);
    dqs_oe_d   = (state_d inside {ST_RD_PRE, ST_RD_DATA, ST_RD_POST});
    dqs_t_d    = (state_d == ST_RD_DATA) && !beat_d[0];
    dq_out_d   = (state_d == ST_RD_DATA) ? w_rd_word : '0;
    wr_valid_d = (state_q == ST_WR_DONE);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dq_oe_q    <= 1'b0;
      dqs_oe_q   <= 1'b0;
      dqs_t_q    <= 1'b0;
      dq_out_q   <= '0;
      wr_valid_q <= 1'b0;
    end else begin
      dq_oe_q    <= dq_oe_d;
      dqs_oe_q   <= dqs_oe_d;
      dqs_t_q    <= dqs_t_d;
      dq_out_q   <= dq_out_d;
      wr_valid_q <= wr_valid_d;
    end
  end

  // A write DQS that fails to toggle between adjacent beats latches the error.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      col_q      <= '0;
      dqs_prev_q <= 1'b0;
      dqs_err_q  <= 1'b0;
    end else begin
      if (w_accept) col_q <= bus.cmd_col;
      if (w_capture) begin
        dqs_prev_q <= bus.dqs_t_in;
        if ((beat_q != '0) && (bus.dqs_t_in == dqs_prev_q)) dqs_err_q <= 1'b1;
      end
    end
  end

  assign bus.cmd_ready      = (state_q == ST_IDLE);
  assign bus.dq_oe          = dq_oe_q;
  assign bus.dqs_oe         = dqs_oe_q;
  assign bus.dqs_t_out      = dqs_t_q;
  assign bus.dq_out         = dq_out_q;
  assign bus.wr_burst_valid = wr_valid_q;
  assign bus.dqs_err        = dqs_err_q;

endmodule
`default_nettype wire
